muldiv_seq: RTL

//  Iterative RV32M multiply/divide sequencer for the EX stage of the pipeline.

---
 rtl/muldiv_pkg.sv | 32 +++
 rtl/muldiv_if.sv | 28 ++
 rtl/muldiv_step.sv | 37 +++
 rtl/muldiv_seq.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op codes, FSM encoding and width default for the RV32M sequencer
// Purpose: funct3 op codes, sequencer state encoding, default XLEN.
// Ports: none (package).
package muldiv_pkg;

    localparam int XLEN_DEF = 32;

    typedef enum logic [2:0] {
        F3_MUL    = 3'b000,
        F3_MULH   = 3'b001,
        F3_MULHSU = 3'b010,
        F3_MULHU  = 3'b011,
        F3_DIV    = 3'b100,
        F3_DIVU   = 3'b101,
        F3_REM    = 3'b110,
        F3_REMU   = 3'b111
    } funct3_e;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_CALC = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_e;

    // All divide/remainder ops have funct3[2] set.
    function automatic logic is_div_op(input logic [2:0] f3);
        return f3[2];
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// rtl/muldiv_if.sv - EX-stage handshake bundle between pipeline and muldiv sequencer
// Purpose: groups op request, operands, stall/done status and result.
// Ports (signals): start_E, flush_E, funct3_E, op_a_E, op_b_E (pipeline -> sequencer);
//                  busy, stall_req, done, result (sequencer -> pipeline).
// Modports: master (pipeline side), slave (sequencer side).
interface muldiv_if #(
    parameter int XLEN = 32
);
    logic            start_E;
    logic            flush_E;
    logic [2:0]      funct3_E;
    logic [XLEN-1:0] op_a_E;
    logic [XLEN-1:0] op_b_E;
    logic            busy;
    logic            stall_req;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start_E, flush_E, funct3_E, op_a_E, op_b_E,
        input  busy, stall_req, done, result
    );

    modport slave (
        input  start_E, flush_E, funct3_E, op_a_E, op_b_E,
        output busy, stall_req, done, result
    );
endinterface

// File: rtl/muldiv_step.sv
// rtl/muldiv_step.sv - one radix-2 iteration: shift-add multiply or restoring-divide step
// Purpose: purely combinational; the sequencer owns all registers.
// Ports: i_div (1 = divide step), i_acc (acc / partial remainder), i_lo (multiplier / quotient),
//        i_op (multiplicand / divisor), o_acc, o_lo (next acc / lo).
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic            i_div,
    input  logic [XLEN-1:0] i_acc,
    input  logic [XLEN-1:0] i_lo,
    input  logic [XLEN-1:0] i_op,
    output logic [XLEN-1:0] o_acc,
    output logic [XLEN-1:0] o_lo
);
    logic [XLEN:0] w_sum;
    logic [XLEN:0] w_sh;
    logic [XLEN:0] w_diff;
    logic          w_borrow;

    // Multiply: add multiplicand on lsb of multiplier, then shift {carry,acc,lo} right.
    assign w_sum = {1'b0, i_acc} + (i_lo[0] ? {1'b0, i_op} : '0);

    // Divide: shift {rem,quot} left, trial-subtract divisor. Partial remainder stays
    // below the divisor, so bit XLEN of the difference is exactly the borrow.
    assign w_sh     = {i_acc, i_lo[XLEN-1]};
    assign w_diff   = w_sh - {1'b0, i_op};
    assign w_borrow = w_diff[XLEN];

    always_comb begin
        o_acc = w_sum[XLEN:1];
        o_lo  = {w_sum[0], i_lo[XLEN-1:1]};
        if (i_div) begin
            o_acc = w_borrow ? w_sh[XLEN-1:0] : w_diff[XLEN-1:0];
            o_lo  = {i_lo[XLEN-2:0], ~w_borrow};
        end
    end
endmodule

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - iterative RV32M multiply/divide sequencer for the EX stage
// Purpose: accepts one M op, runs XLEN shift-add / restoring-divide iterations, stalls F/D/E.
// Ports: clk, rst (sync active-high); bus (muldiv_if.slave): start_E, flush_E, funct3_E,
//        op_a_E, op_b_E in; busy, stall_req, done, result out.
// Config: MULDIV_EARLY_OUT_EN - skip the loop for divide-by-zero and multiply by zero.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int XLEN  = XLEN_DEF,
    parameter int CNT_W = $clog2(XLEN)
) (
    input  logic   clk,
    input  logic   rst,
    muldiv_if.slave bus
);
    state_e          r_state, w_next;
    funct3_e         r_f3;
    logic [XLEN-1:0] r_a, r_b;       // original operands, kept for special cases
    logic [XLEN-1:0] r_acc, r_lo;    // {acc,lo}: product, or {remainder,quotient}
    logic [XLEN-1:0] r_op;           // multiplicand or divisor magnitude
    logic            r_neg;          // final result must be negated
    logic [CNT_W-1:0] r_cnt;
    logic [XLEN-1:0] r_result;

    logic            w_div, w_a_neg, w_b_neg, w_div0, w_ovf, w_early;
    logic [XLEN-1:0] w_a_mag, w_b_mag, w_acc_nx, w_lo_nx, w_hi_neg, w_fix_res;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    assign w_div = is_div_op(r_f3);
    // Signed a: MULH, MULHSU, DIV, REM. Signed b: MULH, DIV, REM.
    assign w_a_neg = r_a[XLEN-1] && (r_f3 == F3_MULH || r_f3 == F3_MULHSU ||
                                     r_f3 == F3_DIV  || r_f3 == F3_REM);
    assign w_b_neg = r_b[XLEN-1] && (r_f3 == F3_MULH || r_f3 == F3_DIV || r_f3 == F3_REM);
    assign w_a_mag = w_a_neg ? -r_a : r_a;
    assign w_b_mag = w_b_neg ? -r_b : r_b;
    assign w_div0  = (r_b == '0);
    assign w_ovf   = (r_f3 == F3_DIV || r_f3 == F3_REM) && r_a == MIN_NEG && r_b == '1;

    // High half of -{acc,lo}: carry into the high word only when the low word is zero.
    assign w_hi_neg = ~r_acc + {{(XLEN-1){1'b0}}, (r_lo == '0)};

    muldiv_step #(.XLEN(XLEN)) u_step (
        .i_div (w_div),
        .i_acc (r_acc),
        .i_lo  (r_lo),
        .i_op  (r_op),
        .o_acc (w_acc_nx),
        .o_lo  (w_lo_nx)
    );

    always_comb begin
        w_fix_res = r_lo;
        case (r_f3)
            F3_MUL:                       w_fix_res = r_lo;
            F3_MULH, F3_MULHSU, F3_MULHU: w_fix_res = r_neg ? w_hi_neg : r_acc;
            F3_DIV, F3_DIVU:              w_fix_res = w_div0 ? '1 : w_ovf ? MIN_NEG :
                                                      (r_neg ? -r_lo : r_lo);
            F3_REM, F3_REMU:              w_fix_res = w_div0 ? r_a : w_ovf ? '0 :
                                                      (r_neg ? -r_acc : r_acc);
            default:                      w_fix_res = r_lo;
        endcase
    end

`ifdef MULDIV_EARLY_OUT_EN
    logic [XLEN-1:0] w_early_res;
    assign w_early     = w_div ? w_div0 : (r_a == '0 || w_div0);
    assign w_early_res = w_div ? (r_f3[1] ? r_a : '1) : '0;
`else
    assign w_early = 1'b0;
`endif

    always_comb begin
        w_next        = r_state;
        bus.stall_req = 1'b0;
        case (r_state)
            S_IDLE: begin
                bus.stall_req = bus.start_E & ~bus.flush_E;
                if (bus.start_E && !bus.flush_E) w_next = S_PREP;
            end
            S_PREP: begin
                bus.stall_req = 1'b1;
                w_next        = w_early ? S_DONE : S_CALC;
            end
            S_CALC: begin
                bus.stall_req = 1'b1;
                if (r_cnt == CNT_W'(XLEN-1)) w_next = S_FIX;
            end
            S_FIX: begin
                bus.stall_req = 1'b1;
                w_next        = S_DONE;
            end
            default: w_next = S_IDLE;
        endcase
        if (bus.flush_E) w_next = S_IDLE;
    end

    assign bus.busy   = (r_state != S_IDLE);
    assign bus.done   = (r_state == S_DONE);
    assign bus.result = r_result;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_f3     <= F3_MUL;
            r_a      <= '0;
            r_b      <= '0;
            r_acc    <= '0;
            r_lo     <= '0;
            r_op     <= '0;
            r_neg    <= 1'b0;
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: if (bus.start_E) begin
                    r_f3 <= funct3_e'(bus.funct3_E);
                    r_a  <= bus.op_a_E;
                    r_b  <= bus.op_b_E;
                end
                S_PREP: begin
                    r_lo  <= w_div ? w_a_mag : w_b_mag;
                    r_op  <= w_div ? w_b_mag : w_a_mag;
                    r_acc <= '0;
                    r_cnt <= '0;
                    // REM/REMU follow the dividend's sign; everything else a^b.
                    r_neg <= (r_f3[2] && r_f3[1]) ? w_a_neg : (w_a_neg ^ w_b_neg);
                end
                S_CALC: begin
                    r_acc <= w_acc_nx;
                    r_lo  <= w_lo_nx;
                    r_cnt <= r_cnt + 1'b1;
                end
                default: ;
            endcase
            // A flush forces w_next to IDLE, so the result only moves on a real completion.
            if (w_next == S_DONE) begin
`ifdef MULDIV_EARLY_OUT_EN
                r_result <= (r_state == S_PREP) ? w_early_res : w_fix_res;
`else
                r_result <= w_fix_res;
`endif
            end
        end
    end
endmodule
